// File: rtl/parking_gate_ctrl_pkg.sv
// Shared encodings for the parking gate controller: FSM states and gate direction.
package parking_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

endpackage

// File: rtl/parking_gate_ctrl_gate_timer.sv
// Gate-open down-counter: load a start value, count down to zero, flag terminal count.
module gate_timer #(
    parameter int TMR_W = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [TMR_W-1:0] r_timer;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (i_load) begin
            r_timer <= i_load_val;
        end else if (i_dec && (r_timer != '0)) begin
            r_timer <= r_timer - 1'b1;
        end
    end

    assign o_done = (r_timer == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Single-gate parking controller: round-robin entry/exit arbitration, timed gate
// opening and occupancy tracking.
//   state    | meaning
//   ST_IDLE  | gate closed, arbitrating pending requests
//   ST_OPEN  | gate held open for one car, timer counting down
//   ST_CLOSE | one closed cycle before the next grant
module parking_gate_ctrl
    import parking_gate_ctrl_pkg::*;
#(
    parameter int CAPACITY    = 9,
    parameter int CNT_W       = 4,
    parameter int GATE_CYCLES = 50000000,
    parameter int TMR_W       = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             entry_pulse,
    input  logic             exit_pulse,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             gate_open,
    output logic             gate_dir,
    output logic             reject,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CAP_VAL  = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(GATE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_pend_in;
    logic             r_pend_out;
    logic             r_last_grant;
    logic             r_reject;
    logic [CNT_W-1:0] r_count;

    logic w_idle;
    logic w_full;
    logic w_empty;
    logic w_grant_in;
    logic w_grant_out;
    logic w_admit;
    logic w_refuse;
    logic w_tmr_done;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_full  = (r_count == CAP_VAL);
    assign w_empty = (r_count == '0);

    // With both pending, the direction not served last wins.
    assign w_grant_in  = w_idle & r_pend_in & (~r_pend_out | (r_last_grant == DIR_OUT));
    assign w_grant_out = w_idle & r_pend_out & ~w_grant_in;
    assign w_admit     = (w_grant_in & ~w_full) | (w_grant_out & ~w_empty);
    assign w_refuse    = (w_grant_in & w_full) | (w_grant_out & w_empty);

    gate_timer #(
        .TMR_W (TMR_W)
    ) u_gate_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_admit),
        .i_load_val (LOAD_VAL),
        .i_dec      (r_state == ST_OPEN),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_admit) w_next = ST_OPEN;
            ST_OPEN:  if (w_tmr_done) w_next = ST_CLOSE;
            ST_CLOSE: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // A pulse in the grant cycle re-sets its flag, so it is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_in    <= 1'b0;
            r_pend_out   <= 1'b0;
            r_last_grant <= DIR_OUT;
            r_reject     <= 1'b0;
            r_count      <= '0;
        end else begin
            r_pend_in  <= (r_pend_in & ~w_grant_in) | entry_pulse;
            r_pend_out <= (r_pend_out & ~w_grant_out) | exit_pulse;
            r_reject   <= w_refuse;
            if (w_grant_in && !w_full) begin
                r_count <= r_count + 1'b1;
            end else if (w_grant_out && !w_empty) begin
                r_count <= r_count - 1'b1;
            end
            if (w_admit) begin
                r_last_grant <= w_grant_in ? DIR_IN : DIR_OUT;
            end
        end
    end

    always_comb begin
        gate_open = (r_state == ST_OPEN);
        busy      = (r_state != ST_IDLE) | r_pend_in | r_pend_out;
    end

    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign gate_dir = r_last_grant;
    assign reject   = r_reject;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl: expected gate windows and rejects are queued
// as stimulus is issued and matched by a monitor as the DUT produces them.
`timescale 1ns/100ps
module tb_parking_gate_ctrl;

    localparam int CAPACITY    = 9;
    localparam int CNT_W       = 4;
    localparam int GATE_CYCLES = 4;
    localparam int TMR_W       = 3;

    typedef struct {
        bit is_rej;
        bit dir;
        int cnt;
        int width;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             entry_pulse = 1'b0;
    logic             exit_pulse = 1'b0;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             gate_open;
    logic             gate_dir;
    logic             reject;
    logic             busy;

    int   checks = 0;
    int   failures = 0;
    int   model_cnt = 0;
    exp_t q[$];

    bit   mon_prev = 1'b0;
    bit   mon_dir = 1'b0;
    int   mon_cnt = 0;
    int   mon_width = 0;

    parking_gate_ctrl #(
        .CAPACITY    (CAPACITY),
        .CNT_W       (CNT_W),
        .GATE_CYCLES (GATE_CYCLES),
        .TMR_W       (TMR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .entry_pulse (entry_pulse),
        .exit_pulse  (exit_pulse),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .gate_open   (gate_open),
        .gate_dir    (gate_dir),
        .reject      (reject),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push_gate(input bit dir);
        exp_t e;
        model_cnt = dir ? model_cnt + 1 : model_cnt - 1;
        e.is_rej = 1'b0;
        e.dir    = dir;
        e.cnt    = model_cnt;
        e.width  = GATE_CYCLES;
        q.push_back(e);
    endtask

    task automatic push_rej();
        exp_t e;
        e.is_rej = 1'b1;
        e.dir    = 1'b0;
        e.cnt    = model_cnt;
        e.width  = 0;
        q.push_back(e);
    endtask

    // Each call presents the request(s) across exactly one rising edge.
    task automatic pulse(input bit in_req, input bit out_req);
        @(negedge clk);
        entry_pulse = in_req;
        exit_pulse  = out_req;
        @(negedge clk);
        entry_pulse = 1'b0;
        exit_pulse  = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int  n;
        bit  done;
        done = 1'b0;
        for (n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (q.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        check({tag, "_idle_timeout"}, int'(done), 1);
    endtask

    task automatic wait_gate(input string tag);
        int  n;
        bit  done;
        done = 1'b0;
        for (n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (gate_open === 1'b1) done = 1'b1;
        end
        check({tag, "_gate_timeout"}, int'(done), 1);
    endtask

    task automatic entry_n(input int n);
        for (int i = 0; i < n; i++) begin
            if (model_cnt == CAPACITY) push_rej(); else push_gate(1'b1);
            pulse(1'b1, 1'b0);
            wait_idle("fill");
        end
    endtask

    // Scoreboard consumer: completed gate windows and reject pulses.
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            mon_prev  = 1'b0;
            mon_width = 0;
        end else begin
            if (gate_open === 1'b1) begin
                if (!mon_prev) begin
                    mon_dir   = gate_dir;
                    mon_cnt   = int'(count);
                    mon_width = 1;
                end else begin
                    mon_width++;
                end
            end else if (mon_prev) begin
                check("gate_expected", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("gate_kind", int'(e.is_rej), 0);
                    check("gate_dir", int'(mon_dir), int'(e.dir));
                    check("gate_count", mon_cnt, e.cnt);
                    check("gate_width", mon_width, e.width);
                end
            end
            if (reject === 1'b1) begin
                check("reject_expected", int'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("reject_kind", int'(e.is_rej), 1);
                    check("reject_count", int'(count), e.cnt);
                end
            end
            mon_prev = (gate_open === 1'b1);
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_gate_open", int'(gate_open), 0);
        check("rst_gate_dir", int'(gate_dir), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_busy", int'(busy), 0);

        // Single entry
        push_gate(1'b1);
        pulse(1'b1, 1'b0);
        check("t1_busy_pending", int'(busy), 1);
        check("t1_count_before", int'(count), 0);
        wait_gate("t1");
        check("t1_count_grant", int'(count), 1);
        check("t1_empty", int'(empty), 0);
        check("t1_dir", int'(gate_dir), 1);
        wait_idle("t1");
        check("t1_busy_done", int'(busy), 0);

        // Reach count 3 with an exit last, then contested request
        entry_n(3);
        push_gate(1'b0);
        pulse(1'b0, 1'b1);
        wait_idle("t2_pre");
        check("t2_pre_count", int'(count), 3);
        push_gate(1'b1);
        push_gate(1'b0);
        pulse(1'b1, 1'b1);
        wait_idle("t2");
        check("t2_count", int'(count), 3);

        // Fill to capacity, then one more entry is refused
        entry_n(6);
        check("t3_full_before", int'(full), 1);
        push_rej();
        pulse(1'b1, 1'b0);
        wait_idle("t3");
        check("t3_count", int'(count), 9);
        check("t3_full", int'(full), 1);

        // Exit from an empty lot
        @(negedge clk);
        rst_n = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        push_rej();
        pulse(1'b0, 1'b1);
        wait_idle("t4");
        check("t4_count", int'(count), 0);
        check("t4_empty", int'(empty), 1);

        // Three back-to-back entry pulses while the gate is open
        push_gate(1'b1);
        push_gate(1'b1);
        pulse(1'b1, 1'b0);
        wait_gate("t5");
        entry_pulse = 1'b1;
        repeat (3) @(negedge clk);
        entry_pulse = 1'b0;
        wait_idle("t5");
        check("t5_count", int'(count), 2);

        // Asynchronous reset mid-OPEN; this window is aborted, not queued
        pulse(1'b1, 1'b0);
        wait_gate("t6");
        #2.3;
        rst_n = 1'b0;
        #0.4;
        check("t6_gate_open", int'(gate_open), 0);
        check("t6_count", int'(count), 0);
        check("t6_busy", int'(busy), 0);
        #0.6;
        rst_n = 1'b1;
        model_cnt = 0;
        push_gate(1'b1);
        pulse(1'b1, 1'b0);
        wait_idle("t6_after");
        check("t6_after_count", int'(count), 1);

        check("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
